// File: rtl/fpu_fp16_to_int_pkg.sv
// Shared FP16 types and constants for the fp16 -> integer decode path.
package fpu_fp16_to_int_pkg;

  localparam int unsigned FP16_W      = 16;
  localparam int unsigned FP16_EXP_W  = 5;
  localparam int unsigned FP16_FRAC_W = 10;
  localparam int unsigned FP16_MANT_W = FP16_FRAC_W + 1;
  localparam int unsigned FP16_BIAS   = 15;
  localparam int unsigned FP16_EUNB_W = 6;
  localparam logic [FP16_EXP_W-1:0] FP16_EXP_MAX = 5'h1F;
  localparam int unsigned CC_W        = 4;

  typedef struct packed {
    logic                   sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_FRAC_W-1:0] frac;
  } fp16_t;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } condCode_t;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_SUB,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp16Class_t;

  // Shift counter width: must hold the largest right shift (10) or left shift.
  function automatic int unsigned fp16_cnt_width(input int unsigned out_w);
    int unsigned max_shift;
    max_shift = (out_w > 22) ? (out_w - 12) : 10;
    return $clog2(max_shift + 1);
  endfunction

endpackage

// File: rtl/fpu_fp16_classify.sv
// Combinational FP16 classifier: operand class plus unbiased exponent.
module fpu_fp16_classify
  import fpu_fp16_to_int_pkg::*;
(
  input  fp16_t                          i_op,
  output fp16Class_t                     o_class,
  output logic signed [FP16_EUNB_W-1:0]  o_exp_unb
);

  // Class from exponent/fraction patterns; everything else is a normal number.
  always_comb begin
    o_class = FP_NORM;
    if (i_op.exp == FP16_EXP_MAX) begin
      o_class = (i_op.frac == '0) ? FP_INF : FP_NAN;
    end else if (i_op.exp == '0) begin
      o_class = (i_op.frac == '0) ? FP_ZERO : FP_SUB;
    end
  end

  assign o_exp_unb = $signed({1'b0, i_op.exp}) - $signed(FP16_EUNB_W'(FP16_BIAS));

endmodule

// File: rtl/fpu_fp16_to_int.sv
// Multi-cycle FP16 -> signed integer converter, truncating toward zero,
// using a one-bit-per-cycle shifter and valid/ready on both sides.
module fpu_fp16_to_int
  import fpu_fp16_to_int_pkg::*;
#(
  parameter int unsigned OUT_W = 16
)(
  input  logic              clock,
  input  logic              reset_L,
  input  logic              inValid,
  output logic              inReady,
  input  logic [FP16_W-1:0] fpuIn,
  output logic              outValid,
  input  logic              outReady,
  output logic [OUT_W-1:0]  intOut,
  output logic [CC_W-1:0]   condCodes
);

  localparam int unsigned CNT_W = fp16_cnt_width(OUT_W);
  localparam logic [OUT_W-1:0] INT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] INT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [FP16_EUNB_W-1:0] E_TOP  = FP16_EUNB_W'(OUT_W - 1);
  localparam logic signed [FP16_EUNB_W-1:0] E_FRAC = FP16_EUNB_W'(FP16_FRAC_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;

  logic [OUT_W-1:0]               r_mant;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_left;
  logic                           r_sign;
  logic                           r_sticky;
  logic                           r_sat;
  logic                           r_nan;

  fp16_t                          w_op;
  fp16Class_t                     w_class;
  logic signed [FP16_EUNB_W-1:0]  w_exp_unb;
  logic                           w_accept;
  logic                           w_out_hs;

  logic [OUT_W-1:0]               w_ld_mant;
  logic [CNT_W-1:0]               w_ld_cnt;
  logic                           w_ld_left;
  logic                           w_ld_sign;
  logic                           w_ld_sticky;
  logic                           w_ld_sat;
  logic                           w_ld_nan;
  logic                           w_exact_min;

  logic                           w_in_ready_nxt;
  logic                           w_out_valid_nxt;
  logic                           w_res_load;
  logic                           w_shift_en;
  logic [OUT_W-1:0]               w_res_int;
  condCode_t                      w_res_cc;
  logic                           w_mag_nz;

  assign w_op     = fp16_t'(fpuIn);
  assign w_accept = (r_state == S_IDLE) && inValid && inReady;
  assign w_out_hs = outValid && outReady;

  fpu_fp16_classify u_classify (
    .i_op      (w_op),
    .o_class   (w_class),
    .o_exp_unb (w_exp_unb)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)     w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == '0)  w_state_nxt = S_DONE;
      S_DONE:  if (w_out_hs)     w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: handshake flags and datapath enables.
  always_comb begin
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (r_state == S_DONE) && !w_out_hs;
    w_res_load      = (r_state == S_SHIFT) && (r_cnt == '0);
    w_shift_en      = (r_state == S_SHIFT) && (r_cnt != '0);
  end

  assign w_exact_min = w_op.sign && (w_exp_unb == E_TOP) && (w_op.frac == '0);

  // Operand decode at accept: special cases resolve here, normals get mantissa and shift plan.
  always_comb begin
    w_ld_mant   = '0;
    w_ld_cnt    = '0;
    w_ld_left   = 1'b0;
    w_ld_sign   = 1'b0;
    w_ld_sticky = 1'b0;
    w_ld_sat    = 1'b0;
    w_ld_nan    = 1'b0;
    case (w_class)
      FP_NAN: begin
        w_ld_nan = 1'b1;
      end
      FP_INF: begin
        w_ld_sat  = 1'b1;
        w_ld_sign = w_op.sign;
      end
      FP_ZERO, FP_SUB: begin
        w_ld_sticky = (w_op.frac != '0);
      end
      default: begin
        if (w_exp_unb < 0) begin
          // |x| < 1 truncates to zero but is inexact.
          w_ld_sticky = 1'b1;
        end else if ((w_exp_unb >= E_TOP) && !w_exact_min) begin
          w_ld_sat  = 1'b1;
          w_ld_sign = w_op.sign;
        end else begin
          w_ld_sign = w_op.sign;
          w_ld_mant = OUT_W'({1'b1, w_op.frac});
          if (w_exp_unb >= E_FRAC) begin
            w_ld_left = 1'b1;
            w_ld_cnt  = CNT_W'(w_exp_unb - E_FRAC);
          end else begin
            w_ld_cnt  = CNT_W'(E_FRAC - w_exp_unb);
          end
        end
      end
    endcase
  end

  // Operand registers: load on accept, then shift one bit per cycle.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_mant   <= '0;
      r_cnt    <= '0;
      r_left   <= 1'b0;
      r_sign   <= 1'b0;
      r_sticky <= 1'b0;
      r_sat    <= 1'b0;
      r_nan    <= 1'b0;
    end else if (w_accept) begin
      r_mant   <= w_ld_mant;
      r_cnt    <= w_ld_cnt;
      r_left   <= w_ld_left;
      r_sign   <= w_ld_sign;
      r_sticky <= w_ld_sticky;
      r_sat    <= w_ld_sat;
      r_nan    <= w_ld_nan;
    end else if (w_shift_en) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_left) begin
        r_mant <= r_mant << 1;
      end else begin
        r_mant   <= r_mant >> 1;
        r_sticky <= r_sticky | r_mant[0];
      end
    end
  end

  // Final result: saturation or signed magnitude, with ZCNV flags.
  always_comb begin
    w_mag_nz  = (r_mant != '0);
    w_res_int = r_sign ? (OUT_W'(0) - r_mant) : r_mant;
    w_res_cc  = '{z: !w_mag_nz, c: r_sticky, n: r_sign && w_mag_nz, v: r_nan};
    if (r_sat) begin
      w_res_int = r_sign ? INT_MIN : INT_MAX;
      w_res_cc  = '{z: 1'b0, c: 1'b0, n: r_sign, v: 1'b1};
    end
  end

  // Registered outputs; result holds until the next conversion overwrites it.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      inReady   <= 1'b0;
      outValid  <= 1'b0;
      intOut    <= '0;
      condCodes <= '0;
    end else begin
      inReady  <= w_in_ready_nxt;
      outValid <= w_out_valid_nxt;
      if (w_res_load) begin
        intOut    <= w_res_int;
        condCodes <= CC_W'(w_res_cc);
      end
    end
  end

endmodule

// File: tb/tb_fpu_fp16_to_int.sv
// Directed bench for fpu_fp16_to_int with hand-computed expected results.
module tb_fpu_fp16_to_int;

  localparam int unsigned OUT_W = 16;

  logic              clock = 1'b0;
  logic              reset_L;
  logic              inValid;
  logic              inReady;
  logic [15:0]       fpuIn;
  logic              outValid;
  logic              outReady;
  logic [OUT_W-1:0]  intOut;
  logic [3:0]        condCodes;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  fpu_fp16_to_int #(.OUT_W(OUT_W)) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .inValid   (inValid),
    .inReady   (inReady),
    .fpuIn     (fpuIn),
    .outValid  (outValid),
    .outReady  (outReady),
    .intOut    (intOut),
    .condCodes (condCodes)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operand; returns just after the accepting edge.
  task automatic send(input logic [15:0] op, input string name);
    @(negedge clock);
    check($sformatf("%s inReady", name), 32'(inReady), 32'd1);
    inValid = 1'b1;
    fpuIn   = op;
    @(posedge clock);
    #1;
    inValid = 1'b0;
  endtask

  // Count edges after acceptance until outValid, bounded.
  task automatic wait_out(output int k);
    k = 0;
    do begin
      @(posedge clock);
      #1;
      k++;
    end while (!outValid && k < 40);
  endtask

  task automatic convert(input logic [15:0] op, input int lat, input logic [15:0] res,
                         input logic [3:0] cc, input string name);
    int k;
    send(op, name);
    wait_out(k);
    check($sformatf("%s latency", name), 32'(k), 32'(lat));
    check($sformatf("%s intOut", name), 32'(intOut), 32'(res));
    check($sformatf("%s ZCNV", name), 32'(condCodes), 32'(cc));
    @(posedge clock);
    #1;
    check($sformatf("%s outValid after hs", name), 32'(outValid), 32'd0);
    check($sformatf("%s inReady after hs", name), 32'(inReady), 32'd1);
  endtask

  initial begin
    int k;
    int seen;
    reset_L  = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    fpuIn    = '0;

    #12;
    check("rst inReady", 32'(inReady), 32'd0);
    check("rst outValid", 32'(outValid), 32'd0);
    check("rst intOut", 32'(intOut), 32'd0);
    check("rst ZCNV", 32'(condCodes), 32'd0);
    @(negedge clock);
    reset_L = 1'b1;
    @(posedge clock);
    #1;
    check("post-rst inReady", 32'(inReady), 32'd1);

    convert(16'h5EF0, 4,  16'h01BC, 4'b0000, "444");
    convert(16'hEA45, 3,  16'hF376, 4'b0010, "-3210");
    convert(16'h3E00, 12, 16'h0001, 4'b0100, "1.5");
    convert(16'hBE00, 12, 16'hFFFF, 4'b0110, "-1.5");
    convert(16'h3800, 2,  16'h0000, 4'b1100, "0.5");
    convert(16'h8000, 2,  16'h0000, 4'b1000, "-0.0");
    convert(16'h0001, 2,  16'h0000, 4'b1100, "subnormal");
    convert(16'h7C00, 2,  16'h7FFF, 4'b0001, "+inf");
    convert(16'hFC00, 2,  16'h8000, 4'b0011, "-inf");
    convert(16'h7E00, 2,  16'h0000, 4'b1001, "nan");
    convert(16'h7800, 2,  16'h7FFF, 4'b0001, "+32768 sat");
    convert(16'hF800, 7,  16'h8000, 4'b0010, "-32768 exact");

    // Backpressure: result must hold and further input is ignored.
    outReady = 1'b0;
    send(16'h4900, "bp");
    wait_out(k);
    check("bp latency", 32'(k), 32'd9);
    check("bp intOut", 32'(intOut), 32'd10);
    check("bp ZCNV", 32'(condCodes), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      inValid = (i == 1);
      fpuIn   = 16'h3C00;
      @(posedge clock);
      #1;
      check($sformatf("bp hold outValid %0d", i), 32'(outValid), 32'd1);
      check($sformatf("bp hold intOut %0d", i), 32'(intOut), 32'd10);
      check($sformatf("bp hold inReady %0d", i), 32'(inReady), 32'd0);
    end
    @(negedge clock);
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clock);
    #1;
    check("bp release outValid", 32'(outValid), 32'd0);
    check("bp release inReady", 32'(inReady), 32'd1);
    check("bp result held", 32'(intOut), 32'd10);

    // Reset in the middle of a shift sequence discards the operation.
    send(16'h3C00, "rst-mid");
    repeat (3) @(posedge clock);
    #2;
    reset_L = 1'b0;
    #1;
    check("mid-rst outValid", 32'(outValid), 32'd0);
    check("mid-rst intOut", 32'(intOut), 32'd0);
    check("mid-rst ZCNV", 32'(condCodes), 32'd0);
    check("mid-rst inReady", 32'(inReady), 32'd0);
    seen = 0;
    repeat (14) begin
      @(posedge clock);
      #1;
      if (outValid) seen++;
    end
    check("mid-rst no output", 32'(seen), 32'd0);
    @(negedge clock);
    reset_L = 1'b1;
    @(posedge clock);
    #1;
    check("mid-rst release inReady", 32'(inReady), 32'd1);
    seen = 0;
    repeat (14) begin
      @(posedge clock);
      #1;
      if (outValid) seen++;
    end
    check("post-rst idle no output", 32'(seen), 32'd0);
    convert(16'h3C00, 12, 16'h0001, 4'b0000, "1.0");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
